// File: rtl/freq_meter_multi.sv
// freq_meter_multi: counts rising edges of NUM_CH asynchronous inputs over a
// common, runtime-programmable gate window timed in clk_standard cycles.
// Per-channel counters saturate with a sticky overflow flag; windows run
// continuously or single-shot, and dropping enable aborts cleanly to IDLE.
module freq_meter_multi #(
   parameter int NUM_CH      = 4,
   parameter int CNT_W       = 32,
   parameter int GATE_W      = 32,
   parameter int SYNC_STAGES = 3,
   parameter int GAP_CYCLES  = 256
) (
   input  logic                    clk_standard,
   input  logic                    rst,
   input  logic                    enable,
   input  logic                    mode_cont,
   input  logic                    start,
   input  logic [GATE_W-1:0]       gate_len,
   input  logic [NUM_CH-1:0]       sig_in,
   output logic                    busy,
   output logic                    valid_freq_out,
   output logic [NUM_CH*CNT_W-1:0] freq_out,
   output logic [NUM_CH-1:0]       overflow
);

   localparam int GAP_W = $clog2(GAP_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_COUNT,
      S_LATCH,
      S_GAP
   } state_t;

   state_t                          state_q, state_d;
   logic [SYNC_STAGES-1:0][NUM_CH-1:0] sync_q, sync_d;
   logic [NUM_CH-1:0]               hist_q, hist_d;
   logic [NUM_CH-1:0]               edge_det;
   logic [GATE_W-1:0]               gate_q, gate_d;
   logic [GATE_W-1:0]               gate_cnt_q, gate_cnt_d;
   logic [GAP_W-1:0]                gap_cnt_q, gap_cnt_d;
   logic [NUM_CH-1:0][CNT_W-1:0]    cnt_q, cnt_d;
   logic [NUM_CH-1:0]               ovf_q, ovf_d;
   logic [NUM_CH-1:0][CNT_W-1:0]    freq_q, freq_d;
   logic [NUM_CH-1:0]               overflow_q, overflow_d;
   logic                            valid_q, valid_d;

   // Synchroniser shift chain and edge-history flop; runs in every state so
   // the history is already settled when a window opens.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], sig_in};
      hist_d = sync_q[SYNC_STAGES-1];
   end

   assign edge_det = sync_q[SYNC_STAGES-1] & ~hist_q;

   // Window sequencing, per-channel counting and result publication.
   always_comb begin
      // NOTE: every variable gets its hold value first, so no path through the
      // case below can leave one unassigned and infer a latch.
      state_d    = state_q;
      gate_d     = gate_q;
      gate_cnt_d = gate_cnt_q;
      gap_cnt_d  = gap_cnt_q;
      cnt_d      = cnt_q;
      ovf_d      = ovf_q;
      freq_d     = freq_q;
      overflow_d = overflow_q;
      valid_d    = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (enable && (mode_cont || start)) state_d = S_ARM;
         end
         S_ARM: begin
            // A zero length would never match the terminal count; run one cycle.
            gate_d     = (gate_len == '0) ? GATE_W'(1) : gate_len;
            gate_cnt_d = '0;
            cnt_d      = '0;
            ovf_d      = '0;
            state_d    = S_COUNT;
         end
         S_COUNT: begin
            for (int i = 0; i < NUM_CH; i++) begin
               if (edge_det[i]) begin
                  if (&cnt_q[i]) ovf_d[i] = 1'b1;
                  else           cnt_d[i] = cnt_q[i] + CNT_W'(1);
               end
            end
            gate_cnt_d = gate_cnt_q + GATE_W'(1);
            if (gate_cnt_q == gate_q - GATE_W'(1)) state_d = S_LATCH;
         end
         S_LATCH: begin
            freq_d     = cnt_q;
            overflow_d = ovf_q;
            valid_d    = 1'b1;
            gap_cnt_d  = '0;
            state_d    = S_GAP;
         end
         S_GAP: begin
            gap_cnt_d = gap_cnt_q + GAP_W'(1);
            if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
               state_d = mode_cont ? S_ARM : S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Abort overrides the next state only; a LATCH in flight still publishes.
      if (!enable && (state_q != S_IDLE)) state_d = S_IDLE;
   end

   // State register; every flop clears asynchronously on rst.
   always_ff @(posedge clk_standard or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         sync_q     <= '0;
         hist_q     <= '0;
         gate_q     <= '0;
         gate_cnt_q <= '0;
         gap_cnt_q  <= '0;
         cnt_q      <= '0;
         ovf_q      <= '0;
         freq_q     <= '0;
         overflow_q <= '0;
         valid_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking updates so every flop samples pre-edge values,
         // which keeps the synchroniser a true shift chain.
         state_q    <= state_d;
         sync_q     <= sync_d;
         hist_q     <= hist_d;
         gate_q     <= gate_d;
         gate_cnt_q <= gate_cnt_d;
         gap_cnt_q  <= gap_cnt_d;
         cnt_q      <= cnt_d;
         ovf_q      <= ovf_d;
         freq_q     <= freq_d;
         overflow_q <= overflow_d;
         valid_q    <= valid_d;
      end
   end

   assign busy           = (state_q != S_IDLE);
   assign valid_freq_out = valid_q;
   assign freq_out       = freq_q;
   assign overflow       = overflow_q;

endmodule

// File: tb/tb_freq_meter_multi.sv
// Bench for freq_meter_multi: a wide-counter instance and a 4-bit-counter
// instance share stimulus, so saturation is exercised alongside normal counts.
// Expected counts come from a log of every driven input value: an input rising
// edge is seen by the counters SYNC cycles after it is presented, and a window
// armed in cycle A counts during cycles A+1 .. A+g.
module tb_freq_meter_multi;

   localparam int NUM_CH = 4;
   localparam int GATE_W = 32;
   localparam int SYNC   = 3;
   localparam int GAP    = 256;
   localparam int WIDE   = 32;
   localparam int NARROW = 4;
   localparam int LOG_N  = 65536;
   localparam int PW     = WIDE + NARROW + 2;

   logic                    clk_standard = 1'b0;
   logic                    rst;
   logic                    enable;
   logic                    mode_cont;
   logic                    start;
   logic [GATE_W-1:0]       gate_len;
   logic [NUM_CH-1:0]       sig_in = '0;
   logic                    busy_w, valid_w, busy_n, valid_n;
   logic [NUM_CH*WIDE-1:0]  freq_w;
   logic [NUM_CH*NARROW-1:0] freq_n;
   logic [NUM_CH-1:0]       ovf_w, ovf_n;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   int ch_mode [NUM_CH];
   int ch_per  [NUM_CH];
   int ch_ph   [NUM_CH];
   bit [NUM_CH-1:0] sig_log [LOG_N];

   freq_meter_multi #(.NUM_CH(NUM_CH), .CNT_W(WIDE), .GATE_W(GATE_W),
                      .SYNC_STAGES(SYNC), .GAP_CYCLES(GAP)) u_dut_wide (
      .clk_standard   (clk_standard),
      .rst            (rst),
      .enable         (enable),
      .mode_cont      (mode_cont),
      .start          (start),
      .gate_len       (gate_len),
      .sig_in         (sig_in),
      .busy           (busy_w),
      .valid_freq_out (valid_w),
      .freq_out       (freq_w),
      .overflow       (ovf_w)
   );

   freq_meter_multi #(.NUM_CH(NUM_CH), .CNT_W(NARROW), .GATE_W(GATE_W),
                      .SYNC_STAGES(SYNC), .GAP_CYCLES(GAP)) u_dut_narrow (
      .clk_standard   (clk_standard),
      .rst            (rst),
      .enable         (enable),
      .mode_cont      (mode_cont),
      .start          (start),
      .gate_len       (gate_len),
      .sig_in         (sig_in),
      .busy           (busy_n),
      .valid_freq_out (valid_n),
      .freq_out       (freq_n),
      .overflow       (ovf_n)
   );

   always #5 clk_standard = ~clk_standard;

   // Cycle index: cycle n is the interval that begins at the n-th rising edge.
   always @(posedge clk_standard) cyc <= cyc + 1;

   // Per-channel input generator: constant, square wave, or random bits.
   always begin
      @(posedge clk_standard);
      #1;
      for (int c = 0; c < NUM_CH; c++) begin
         case (ch_mode[c])
            0:       sig_in[c] = 1'b0;
            1:       sig_in[c] = 1'b1;
            2:       sig_in[c] = ((cyc + ch_ph[c]) % ch_per[c]) < (ch_per[c] / 2);
            default: sig_in[c] = 1'($urandom_range(0, 1));
         endcase
      end
      sig_log[cyc] = sig_in;
   end

   // Reference: rising edges presented in cycles [A+1-SYNC, A+g-SYNC].
   function automatic int model_count(input int ch, input int arm, input int g);
      int n = 0;
      for (int m = arm + 1 - SYNC; m <= arm + g - SYNC; m++) begin
         if (sig_log[m][ch] && !sig_log[m-1][ch]) n++;
      end
      return n;
   endfunction

   // Expected {wide lane, narrow lane, wide ovf, narrow ovf} for a true count.
   function automatic logic [PW-1:0] exp_pack(input int c);
      int top = (1 << NARROW) - 1;
      return {WIDE'(c), NARROW'((c > top) ? top : c), 1'b0, (c > top)};
   endfunction

   function automatic logic [PW-1:0] got_pack(input int i);
      return {freq_w[i*WIDE +: WIDE], freq_n[i*NARROW +: NARROW], ovf_w[i], ovf_n[i]};
   endfunction

   task automatic tick();
      @(posedge clk_standard);
      #1;
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic set_ch(input int c, input int mode, input int per);
      ch_mode[c] = mode;
      ch_per[c]  = (per < 2) ? 2 : per;
      ch_ph[c]   = $urandom_range(0, ch_per[c] - 1);
   endtask

   task automatic all_random();
      for (int c = 0; c < NUM_CH; c++) set_ch(c, 3, 2);
   endtask

   // Waits up to budget cycles for a valid pulse; t = -1 if none. stray flags
   // results that moved without a pulse or instances that disagree on valid.
   task automatic wait_valid(input int budget, output int t, output bit stray);
      logic [NUM_CH*PW-1:0] held;
      held  = {freq_w, freq_n, ovf_w, ovf_n};
      t     = -1;
      stray = 1'b0;
      for (int k = 0; k < budget; k++) begin
         tick();
         if (valid_w !== valid_n) stray = 1'b1;
         if (valid_w === 1'b1) begin
            t = cyc;
            return;
         end
         if ({freq_w, freq_n, ovf_w, ovf_n} !== held) stray = 1'b1;
      end
   endtask

   task automatic wait_idle(input int budget, output int t);
      t = -1;
      for (int k = 0; k < budget; k++) begin
         tick();
         if (busy_w === 1'b0) begin
            t = cyc;
            return;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; enable = 1'b0; mode_cont = 1'b0; start = 1'b0; gate_len = '0;
      all_random();
      ticks(3);
      n_cmp++;
      if ({busy_w, valid_w, busy_n, valid_n} !== 4'b0) begin
         $display("FAIL reset_ctrl got=%b exp=0000", {busy_w, valid_w, busy_n, valid_n}); n_bad++;
      end
      n_cmp++;
      if ({freq_w, freq_n, ovf_w, ovf_n} !== '0) begin
         $display("FAIL reset_data got=%h exp=0", {freq_w, freq_n, ovf_w, ovf_n}); n_bad++;
      end
      rst = 1'b0;
      ticks(6);
      n_cmp++;
      if (busy_w !== 1'b0) begin
         $display("FAIL reset_idle busy got=%b exp=0", busy_w); n_bad++;
      end
   endtask

   task automatic test_basic_count();
      int arm, t, t2;
      bit stray;
      logic [PW-1:0] want;
      int plan [NUM_CH] = '{25, 10, 0, 0};
      set_ch(0, 2, 4); set_ch(1, 2, 10); set_ch(2, 0, 0); set_ch(3, 1, 0);
      mode_cont = 1'b1; gate_len = 100;
      ticks(6);
      enable = 1'b1; arm = cyc + 1;
      wait_valid(300, t, stray);
      n_cmp++;
      if (t !== arm + 102 || stray) begin
         $display("FAIL basic_first_valid got=%0d/%0b exp=%0d/0", t, stray, arm + 102); n_bad++;
      end
      for (int i = 0; i < NUM_CH; i++) begin
         want = exp_pack(model_count(i, arm, 100));
         n_cmp++;
         if (got_pack(i) !== want) begin
            $display("FAIL basic_lane%0d got=%h exp=%h", i, got_pack(i), want); n_bad++;
         end
         n_cmp++;
         if ({freq_w[i*WIDE +: WIDE], ovf_w[i]} !== {WIDE'(plan[i]), 1'b0}) begin
            $display("FAIL basic_plan%0d got=%0d exp=%0d", i, freq_w[i*WIDE +: WIDE], plan[i]); n_bad++;
         end
      end
      tick();
      n_cmp++;
      if (valid_w !== 1'b0) begin
         $display("FAIL basic_pulse_width valid got=%b exp=0", valid_w); n_bad++;
      end
      wait_valid(500, t2, stray);
      n_cmp++;
      if (t2 - t !== 358 || stray) begin
         $display("FAIL basic_period got=%0d/%0b exp=358/0", t2 - t, stray); n_bad++;
      end
      for (int i = 0; i < NUM_CH; i++) begin
         want = exp_pack(model_count(i, t + GAP, 100));
         n_cmp++;
         if (got_pack(i) !== want) begin
            $display("FAIL basic_w2_lane%0d got=%h exp=%h", i, got_pack(i), want); n_bad++;
         end
      end
      enable = 1'b0;
      ticks(2);
      n_cmp++;
      if (busy_w !== 1'b0) begin
         $display("FAIL basic_disable busy got=%b exp=0", busy_w); n_bad++;
      end
   endtask

   task automatic test_odd_zero_gate();
      int arm, t, ti;
      bit stray;
      logic [PW-1:0] want;
      all_random(); set_ch(0, 2, 3);
      mode_cont = 1'b0; gate_len = 99;
      ticks(4);
      enable = 1'b1; start = 1'b1; arm = cyc + 1;
      tick(); start = 1'b0;
      wait_valid(200, t, stray);
      n_cmp++;
      if (t !== arm + 101 || stray) begin
         $display("FAIL odd_valid got=%0d/%0b exp=%0d/0", t, stray, arm + 101); n_bad++;
      end
      n_cmp++;
      if (freq_w[WIDE-1:0] !== WIDE'(33)) begin
         $display("FAIL odd_ch0 got=%0d exp=33", freq_w[WIDE-1:0]); n_bad++;
      end
      for (int i = 0; i < NUM_CH; i++) begin
         want = exp_pack(model_count(i, arm, 99));
         n_cmp++;
         if (got_pack(i) !== want) begin
            $display("FAIL odd_lane%0d got=%h exp=%h", i, got_pack(i), want); n_bad++;
         end
      end
      wait_idle(400, ti);
      n_cmp++;
      if (ti !== t + GAP) begin
         $display("FAIL odd_busy_fall got=%0d exp=%0d", ti, t + GAP); n_bad++;
      end
      set_ch(0, 2, 2); gate_len = 0;
      ticks(4);
      start = 1'b1; arm = cyc + 1;
      tick(); start = 1'b0;
      wait_valid(50, t, stray);
      n_cmp++;
      if (t !== arm + 3 || stray) begin
         $display("FAIL zero_gate_valid got=%0d/%0b exp=%0d/0", t, stray, arm + 3); n_bad++;
      end
      for (int i = 0; i < NUM_CH; i++) begin
         want = exp_pack(model_count(i, arm, 1));
         n_cmp++;
         if (got_pack(i) !== want) begin
            $display("FAIL zero_gate_lane%0d got=%h exp=%h", i, got_pack(i), want); n_bad++;
         end
      end
      wait_idle(400, ti);
      enable = 1'b0;
   endtask

   task automatic test_overflow();
      int arm, arm2, t, t2, ti;
      bit stray;
      logic [PW-1:0] want;
      all_random(); set_ch(0, 2, 2);
      mode_cont = 1'b1; gate_len = 64;
      ticks(4);
      enable = 1'b1; arm = cyc + 1;
      ticks(10);
      gate_len = 8;
      wait_valid(200, t, stray);
      n_cmp++;
      if (t !== arm + 66 || stray) begin
         $display("FAIL ovf_valid got=%0d/%0b exp=%0d/0", t, stray, arm + 66); n_bad++;
      end
      n_cmp++;
      if ({freq_n[NARROW-1:0], ovf_n[0], freq_w[WIDE-1:0]} !== {4'hF, 1'b1, WIDE'(32)}) begin
         $display("FAIL ovf_sat got=%0d/%b/%0d exp=15/1/32", freq_n[NARROW-1:0], ovf_n[0], freq_w[WIDE-1:0]); n_bad++;
      end
      for (int i = 0; i < NUM_CH; i++) begin
         want = exp_pack(model_count(i, arm, 64));
         n_cmp++;
         if (got_pack(i) !== want) begin
            $display("FAIL ovf_lane%0d got=%h exp=%h", i, got_pack(i), want); n_bad++;
         end
      end
      arm2 = t + GAP;
      while (cyc < arm2 + 3) tick();
      mode_cont = 1'b0;
      wait_valid(100, t2, stray);
      n_cmp++;
      if (t2 !== arm2 + 10 || stray) begin
         $display("FAIL ovf_w2_valid got=%0d/%0b exp=%0d/0", t2, stray, arm2 + 10); n_bad++;
      end
      n_cmp++;
      if ({freq_n[NARROW-1:0], ovf_n[0]} !== {4'h4, 1'b0}) begin
         $display("FAIL ovf_clear got=%0d/%b exp=4/0", freq_n[NARROW-1:0], ovf_n[0]); n_bad++;
      end
      for (int i = 0; i < NUM_CH; i++) begin
         want = exp_pack(model_count(i, arm2, 8));
         n_cmp++;
         if (got_pack(i) !== want) begin
            $display("FAIL ovf_w2_lane%0d got=%h exp=%h", i, got_pack(i), want); n_bad++;
         end
      end
      wait_idle(400, ti);
      n_cmp++;
      if (ti !== t2 + GAP) begin
         $display("FAIL ovf_mode_exit got=%0d exp=%0d", ti, t2 + GAP); n_bad++;
      end
      enable = 1'b0;
   endtask

   task automatic test_single_shot();
      int arm, t, ti, t3;
      bit stray;
      logic [PW-1:0] want;
      all_random(); set_ch(0, 2, 5);
      mode_cont = 1'b0; gate_len = 50;
      ticks(4);
      enable = 1'b1; start = 1'b1; arm = cyc + 1;
      tick(); start = 1'b0;
      ticks(20);
      start = 1'b1; tick(); start = 1'b0;
      wait_valid(100, t, stray);
      n_cmp++;
      if (t !== arm + 52 || stray) begin
         $display("FAIL single_valid got=%0d/%0b exp=%0d/0", t, stray, arm + 52); n_bad++;
      end
      n_cmp++;
      if (freq_w[WIDE-1:0] !== WIDE'(10)) begin
         $display("FAIL single_ch0 got=%0d exp=10", freq_w[WIDE-1:0]); n_bad++;
      end
      for (int i = 0; i < NUM_CH; i++) begin
         want = exp_pack(model_count(i, arm, 50));
         n_cmp++;
         if (got_pack(i) !== want) begin
            $display("FAIL single_lane%0d got=%h exp=%h", i, got_pack(i), want); n_bad++;
         end
      end
      ticks(5);
      start = 1'b1; tick(); start = 1'b0;
      wait_idle(400, ti);
      n_cmp++;
      if (ti !== t + GAP) begin
         $display("FAIL single_busy_fall got=%0d exp=%0d", ti, t + GAP); n_bad++;
      end
      wait_valid(600, t3, stray);
      n_cmp++;
      if (t3 !== -1 || stray || busy_w !== 1'b0) begin
         $display("FAIL single_no_retrigger got=%0d/%0b/%b exp=-1/0/0", t3, stray, busy_w); n_bad++;
      end
      enable = 1'b0;
   endtask

   task automatic test_abort();
      int arm, arm2, t, t3;
      bit stray;
      logic [PW-1:0] want;
      logic [PW-1:0] prev [NUM_CH];
      all_random();
      mode_cont = 1'b1; gate_len = 100;
      ticks(4);
      enable = 1'b1; arm = cyc + 1;
      wait_valid(200, t, stray);
      n_cmp++;
      if (t !== arm + 102 || stray) begin
         $display("FAIL abort_w1_valid got=%0d/%0b exp=%0d/0", t, stray, arm + 102); n_bad++;
      end
      for (int i = 0; i < NUM_CH; i++) prev[i] = exp_pack(model_count(i, arm, 100));
      arm2 = t + GAP;
      while (cyc < arm2 + 40) tick();
      n_cmp++;
      if (busy_w !== 1'b1) begin
         $display("FAIL abort_busy_before got=%b exp=1", busy_w); n_bad++;
      end
      enable = 1'b0;
      tick();
      n_cmp++;
      if (busy_w !== 1'b0) begin
         $display("FAIL abort_idle_next got=%b exp=0", busy_w); n_bad++;
      end
      wait_valid(500, t3, stray);
      n_cmp++;
      if (t3 !== -1 || stray) begin
         $display("FAIL abort_no_valid got=%0d/%0b exp=-1/0", t3, stray); n_bad++;
      end
      for (int i = 0; i < NUM_CH; i++) begin
         n_cmp++;
         if (got_pack(i) !== prev[i]) begin
            $display("FAIL abort_hold_lane%0d got=%h exp=%h", i, got_pack(i), prev[i]); n_bad++;
         end
      end
      enable = 1'b1; arm = cyc + 1;
      wait_valid(200, t, stray);
      n_cmp++;
      if (t !== arm + 102 || stray) begin
         $display("FAIL abort_reenable_valid got=%0d/%0b exp=%0d/0", t, stray, arm + 102); n_bad++;
      end
      for (int i = 0; i < NUM_CH; i++) begin
         want = exp_pack(model_count(i, arm, 100));
         n_cmp++;
         if (got_pack(i) !== want) begin
            $display("FAIL abort_reenable_lane%0d got=%h exp=%h", i, got_pack(i), want); n_bad++;
         end
      end
      enable = 1'b0;
      ticks(2);
   endtask

   task automatic test_abort_in_latch();
      int arm, t;
      bit stray;
      logic [PW-1:0] want;
      all_random();
      mode_cont = 1'b1; gate_len = 20;
      ticks(4);
      enable = 1'b1; arm = cyc + 1;
      while (cyc < arm + 21) tick();
      enable = 1'b0;
      wait_valid(10, t, stray);
      n_cmp++;
      if (t !== arm + 22 || stray || busy_w !== 1'b0) begin
         $display("FAIL latch_abort got=%0d/%0b/%b exp=%0d/0/0", t, stray, busy_w, arm + 22); n_bad++;
      end
      for (int i = 0; i < NUM_CH; i++) begin
         want = exp_pack(model_count(i, arm, 20));
         n_cmp++;
         if (got_pack(i) !== want) begin
            $display("FAIL latch_abort_lane%0d got=%h exp=%h", i, got_pack(i), want); n_bad++;
         end
      end
      ticks(2);
   endtask

   task automatic test_reset_mid();
      int arm, t;
      bit stray;
      logic [PW-1:0] want;
      all_random();
      mode_cont = 1'b1; gate_len = 100;
      ticks(4);
      enable = 1'b1; arm = cyc + 1;
      while (cyc < arm + 30) tick();
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({busy_w, valid_w, busy_n, valid_n, freq_w, freq_n, ovf_w, ovf_n} !== '0) begin
         $display("FAIL reset_mid_outputs got=%h exp=0",
                  {busy_w, valid_w, busy_n, valid_n, freq_w, freq_n, ovf_w, ovf_n}); n_bad++;
      end
      enable = 1'b0;
      ticks(2);
      rst = 1'b0;
      ticks(5);
      enable = 1'b1; arm = cyc + 1;
      wait_valid(200, t, stray);
      n_cmp++;
      if (t !== arm + 102 || stray) begin
         $display("FAIL reset_mid_valid got=%0d/%0b exp=%0d/0", t, stray, arm + 102); n_bad++;
      end
      for (int i = 0; i < NUM_CH; i++) begin
         want = exp_pack(model_count(i, arm, 100));
         n_cmp++;
         if (got_pack(i) !== want) begin
            $display("FAIL reset_mid_lane%0d got=%h exp=%h", i, got_pack(i), want); n_bad++;
         end
      end
      enable = 1'b0;
      ticks(2);
   endtask

   task automatic test_random_windows();
      int arm, t, g, ge;
      bit stray;
      logic [PW-1:0] want;
      all_random();
      mode_cont = 1'b1;
      g = $urandom_range(0, 40); gate_len = g;
      ticks(4);
      enable = 1'b1; arm = cyc + 1;
      for (int w = 0; w < 5; w++) begin
         ge = (g == 0) ? 1 : g;
         wait_valid(GAP + 60, t, stray);
         n_cmp++;
         if (t !== arm + ge + 2 || stray) begin
            $display("FAIL rand_w%0d_valid got=%0d/%0b exp=%0d/0", w, t, stray, arm + ge + 2); n_bad++;
         end
         for (int i = 0; i < NUM_CH; i++) begin
            want = exp_pack(model_count(i, arm, ge));
            n_cmp++;
            if (got_pack(i) !== want) begin
               $display("FAIL rand_w%0d_lane%0d got=%h exp=%h", w, i, got_pack(i), want); n_bad++;
            end
         end
         for (int c = 0; c < NUM_CH; c++) set_ch(c, $urandom_range(0, 3), $urandom_range(2, 9));
         g = $urandom_range(0, 40); gate_len = g;
         arm = t + GAP;
      end
      enable = 1'b0;
      ticks(2);
   endtask

   initial begin
      test_reset();
      test_basic_count();
      test_odd_zero_gate();
      test_overflow();
      test_single_shot();
      test_abort();
      test_abort_in_latch();
      test_reset_mid();
      test_random_windows();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "simulation time limit reached");
   end

endmodule

// File: doc/freq_meter_multi.md
Name: freq_meter_multi

Overview:
- Multi-channel, single-clock successor to the two-clock frequency counter. Counts rising edges of NUM_CH asynchronous input signals over a common gate window of runtime-programmable length, measured in clk_standard cycles.
- Adds per-channel saturation/overflow flags, continuous or single-shot mode, and a clean abort path.
- Sits beside the atomic-clock control loop and feeds measured counts to the loop-filter/servo logic.

Parameters:
- NUM_CH, 4, number of measured input channels (1..16).
- CNT_W, 32, width of each per-channel edge counter and of each freq_out lane.
- GATE_W, 32, width of the gate_len input.
- SYNC_STAGES, 3, synchroniser flops per channel before edge detection (minimum 2).
- GAP_CYCLES, 256, idle cycles between windows in continuous mode (minimum 1).

Ports:
- clk_standard  input  1  standard reference clock; the only clock.
- rst  input  1  asynchronous reset, active-high.
- enable  input  1  block enable; low forces abort to IDLE.
- mode_cont  input  1  1 = continuous windows, 0 = single-shot.
- start  input  1  single-shot trigger, sampled in IDLE only.
- gate_len  input  GATE_W  window length in clk_standard cycles; 0 is treated as 1; latched in ARM.
- sig_in  input  NUM_CH  asynchronous signals to measure; each must be below clk_standard/2.
- busy  output  1  high in every state except IDLE.
- valid_freq_out  output  1  one-cycle pulse when freq_out/overflow update.
- freq_out  output  NUM_CH*CNT_W  edge counts for the last window; channel i occupies bits [i*CNT_W +: CNT_W].
- overflow  output  NUM_CH  per-channel saturation flag for the last window.

Behaviour:
- Reset: all state async-cleared; busy=0, valid_freq_out=0, freq_out=0, overflow=0, FSM=IDLE, synchronisers=0.
- Input path, per channel: SYNC_STAGES flop chain, then one history flop. edge[i] = sync_last & ~hist. Runs in every state, so no spurious edge appears on entry to COUNT.
- FSM states: IDLE, ARM, COUNT, LATCH, GAP.
- IDLE: go to ARM when enable & (mode_cont | start).
- ARM (1 cycle):
  - latch gate_len (0 becomes 1) into the gate register;
  - clear per-channel counters and sticky overflow bits;
  - clear the gate counter;
  - go to COUNT.
- COUNT: exactly gate_len cycles.
  - Each cycle with edge[i]=1 increments cnt[i].
  - If cnt[i] is all-ones, cnt[i] holds and ovf[i] sets (sticky).
  - On the cycle where gate_cnt == gate_len-1, go to LATCH; edges in that cycle still count.
- LATCH (1 cycle): register freq_out<=cnt and overflow<=ovf; valid_freq_out<=1 (visible the following cycle, for one cycle only); go to GAP.
- GAP: GAP_CYCLES cycles, then ARM if mode_cont else IDLE.
- Continuous window period: 1 + gate_len + 1 + GAP_CYCLES cycles between successive valid pulses.
- Single-shot: a start while busy is ignored; exactly one valid pulse per accepted start.
- enable low in any state other than IDLE: next state is IDLE. Counters are discarded, no valid pulse is issued, and freq_out/overflow keep their previous values. If enable falls in the LATCH cycle, that update still completes.
- gate_len changes take effect only at the next ARM.
- mode_cont changes are sampled only at the GAP exit.
- freq_out and overflow change only on the cycle valid_freq_out is high.
- Mid-operation async reset returns every output to its reset value immediately.

Test Plan:
- Basic count: reset, then enable=1, mode_cont=1, gate_len=100; ch0 period 4 cycles, ch1 period 10, ch2 constant 0, ch3 constant 1 -> each valid shows ch0=25, ch1=10, ch2=0, ch3=0, overflow=0; valid pulses are 358 cycles apart (GAP_CYCLES=256).
- Odd gate / zero gate: gate_len=99 with ch0 period 3 -> 33. gate_len=0 with ch0 period 2 -> counts in {0,1}, window is 1 cycle.
- Overflow: CNT_W=4, gate_len=64, ch0 period 2 -> freq_out ch0=15, overflow[0]=1. Next window with gate_len=8 -> 4, overflow[0]=0.
- Single-shot: mode_cont=0, start pulse, gate_len=50, ch0 period 5 -> exactly one valid with 10; busy falls after GAP; a second start issued while busy produces no extra window.
- Abort: enable dropped at COUNT cycle 40 of 100 -> FSM IDLE next cycle, no valid pulse, freq_out still holds the prior window's values. Re-enable -> next window correct.
- Reset mid-window: assert rst during COUNT -> all outputs 0 immediately. After release -> first result is correct after one full ARM+COUNT+LATCH sequence.
